// File: rtl/button_debouncer_if.sv
`default_nettype none
// =============================================================================
// button_debouncer_if : raw button pin in, debounced level and event strobes out
// Rev 1.0
// =============================================================================
interface button_debouncer_if;
  logic i_btn_raw;
  logic o_db_level;
  logic o_press;
  logic o_release;
  logic o_step;

  modport master (
    output i_btn_raw,
    input  o_db_level,
    input  o_press,
    input  o_release,
    input  o_step
  );

  modport slave (
    input  i_btn_raw,
    output o_db_level,
    output o_press,
    output o_release,
    output o_step
  );
endinterface
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// =============================================================================
// button_debouncer : 2-flop sync, debounce and auto-repeat of one push button
// Rev 1.0
// =============================================================================
module button_debouncer #(
  parameter bit          ACTIVE_LOW      = 1'b1,
  parameter int unsigned DEBOUNCE_CYCLES = 120000,
  parameter int unsigned HOLD_CYCLES     = 6000000,
  parameter int unsigned REPEAT_CYCLES   = 1200000
) (
  input  wire logic         clk,
  input  wire logic         rst,
  button_debouncer_if.slave bus
);

  localparam logic [31:0] c_DEB_LAST    = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] c_HOLD_LAST   = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0] c_REPEAT_LAST = 32'(REPEAT_CYCLES - 1);
  localparam logic        c_RAW_IDLE    = ACTIVE_LOW;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESS_CHK = 3'd1,
    S_HELD      = 3'd2,
    S_REPEAT    = 3'd3,
    S_REL_CHK   = 3'd4
  } state_t;

  state_t      r_state;
  logic [31:0] r_cnt;
  logic        r_sync1;
  logic        r_sync2;
  logic        r_db_level;
  logic        r_press;
  logic        r_release;
  logic        r_step;
  logic        w_btn_s;

  // Sync flops reset to the released pin level so no phantom press follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= c_RAW_IDLE;
      r_sync2 <= c_RAW_IDLE;
    end else begin
      r_sync1 <= bus.i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn_s = r_sync2 ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_db_level <= 1'b0;
      r_press    <= 1'b0;
      r_release  <= 1'b0;
      r_step     <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_step    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_btn_s) begin
            r_state <= S_PRESS_CHK;
            r_cnt   <= '0;
          end
        end
        S_PRESS_CHK: begin
          if (!w_btn_s) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_state    <= S_HELD;
            r_cnt      <= '0;
            r_press    <= 1'b1;
            r_step     <= 1'b1;
            r_db_level <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_HELD: begin
          if (!w_btn_s) begin
            r_state <= S_REL_CHK;
            r_cnt   <= '0;
          end else if (r_cnt == c_HOLD_LAST) begin
            r_state <= S_REPEAT;
            r_cnt   <= '0;
            r_step  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_REPEAT: begin
          if (!w_btn_s) begin
            r_state <= S_REL_CHK;
            r_cnt   <= '0;
          end else if (r_cnt == c_REPEAT_LAST) begin
            r_cnt  <= '0;
            r_step <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_REL_CHK: begin
          // A bounce back to pressed re-enters HELD, so the hold delay starts over.
          if (w_btn_s) begin
            r_state <= S_HELD;
            r_cnt   <= '0;
          end else if (r_cnt == c_DEB_LAST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_release  <= 1'b1;
            r_db_level <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_cnt      <= '0;
          r_db_level <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_db_level = r_db_level;
  assign bus.o_press    = r_press;
  assign bus.o_release  = r_release;
  assign bus.o_step     = r_step;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// =============================================================================
// tb_button_debouncer : directed + random stimulus, scoreboard against a
// run-length / step-schedule reference model.  Rev 1.0
// =============================================================================
module tb_button_debouncer;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  button_debouncer_if bif ();

  button_debouncer #(
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic db;
    logic press;
    logic rel;
    logic step;
  } exp_t;

  exp_t  sb_q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  string phase  = "reset";

  // Reference model: pressed-sample history, run of samples disagreeing with
  // the debounced level, and age since the current hold anchor.
  logic m_hist0 = 1'b0;
  logic m_hist1 = 1'b0;
  logic m_db    = 1'b0;
  int   m_run   = 0;
  int   m_age   = 0;

  task automatic model_edge();
    exp_t e;
    logic s;
    e = '0;
    if (rst) begin
      m_hist0 = 1'b0;
      m_hist1 = 1'b0;
      m_db    = 1'b0;
      m_run   = 0;
      m_age   = 0;
    end else begin
      s       = m_hist1;
      m_hist1 = m_hist0;
      m_hist0 = ~bif.i_btn_raw;
      if (!m_db) begin
        m_run = s ? m_run + 1 : 0;
        if (m_run == D + 1) begin
          m_db    = 1'b1;
          m_run   = 0;
          m_age   = 0;
          e.press = 1'b1;
          e.step  = 1'b1;
        end
      end else if (!s) begin
        m_run = m_run + 1;
        if (m_run == D + 1) begin
          m_db  = 1'b0;
          m_run = 0;
          e.rel = 1'b1;
        end
      end else if (m_run != 0) begin
        m_run = 0;
        m_age = 0;
      end else begin
        m_age = m_age + 1;
        if (m_age == H || (m_age > H && (m_age - H) % R == 0)) e.step = 1'b1;
      end
    end
    e.db = m_db;
    sb_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    exp_t e;
    logic [3:0] a;
    @(negedge clk);
    cyc++;
    a = {bif.o_db_level, bif.o_press, bif.o_release, bif.o_step};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard-empty cyc %0d: got db/press/rel/step=%b, no expected entry", cyc, a);
    end else begin
      e = sb_q.pop_front();
      if (a !== 4'(e)) begin
        errors++;
        $display("FAIL %s cyc %0d: got db/press/rel/step=%b required %b", phase, cyc, a, 4'(e));
      end
    end
  end

  task automatic drive(input logic lvl, input int n);
    bif.i_btn_raw = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    bif.i_btn_raw = 1'b1;
    rst           = 1'b1;
    phase = "reset";
    pulse_reset(3);
    drive(1'b1, 4);

    phase = "clean_press_repeat";
    drive(1'b0, 50);
    phase = "release";
    drive(1'b1, 12);

    phase = "bounce";
    repeat (10) begin
      drive(1'b0, 3);
      drive(1'b1, 1);
    end
    drive(1'b1, 10);

    phase = "glitch_in_repeat";
    drive(1'b0, 25);
    drive(1'b1, 2);
    drive(1'b0, 22);

    phase = "reset_while_held";
    pulse_reset(1);
    drive(1'b0, 15);
    phase = "release_after_reset";
    drive(1'b1, 12);

    phase = "random";
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) pulse_reset(1);
      drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 16)));
    end
    drive(1'b1, 2);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
